// File: rtl/cursor_pkg.sv
// Shared types, sprite image and code enum for the mouse-cursor overlay.
// The arrow image is stored one row per word, column 0 in the top two bits.
package cursor_pkg;

  localparam int SPR_W_DEF = 16;
  localparam int SPR_H_DEF = 16;
  localparam int SPR_AW    = $clog2(SPR_W_DEF * SPR_H_DEF);

  typedef logic [1:0] spr_pix_t;

  typedef enum logic [1:0] {
    TRANSP  = 2'b00,
    OUTLINE = 2'b01,
    FILL    = 2'b10,
    ACCENT  = 2'b11
  } spr_code_e;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_pix_t;

  localparam logic [31:0] ARROW [16] = '{
    32'h4000_0000, 32'h5000_0000, 32'h6400_0000, 32'h6900_0000,
    32'h6A40_0000, 32'h7A90_0000, 32'h6AA4_0000, 32'h6AA9_0000,
    32'h6A55_4000, 32'h6990_0000, 32'h5190_0000, 32'h4064_0000,
    32'h0064_0000, 32'h0019_0000, 32'h0014_0000, 32'h0000_0000
  };

  function automatic spr_pix_t arrow_pix(input logic [3:0] row, input logic [3:0] col);
    logic [31:0] r;
    r = ARROW[row];
    return r[{~col, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle passed between drawing stages.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/cursor_sprite_rom.sv
// Registered-read sprite ROM, one cycle latency; larger sprites tile the 16x16 arrow.
module cursor_sprite_rom
  import cursor_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic                             clk40MHz,
  input  logic [$clog2(SPR_W*SPR_H)-1:0]  addr,
  output spr_pix_t                         code
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  logic [3:0] row;
  logic [3:0] col;

  always_comb begin
    row = 4'(addr[XW+YW-1:XW]);
    col = 4'(addr[XW-1:0]);
  end

  // NOTE: the read register is deliberately not reset; hit_d is reset and masks it.
  always_ff @(posedge clk40MHz) begin
    code <= arrow_pix(row, col);
  end
endmodule

// File: rtl/draw_cursor_sprite.sv
// Mouse-cursor overlay: frame-latched position, blink, click colour, fixed 2-cycle latency.
module draw_cursor_sprite
  import cursor_pkg::*;
#(
  parameter int          SPR_W        = 16,
  parameter int          SPR_H        = 16,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COL_OUTLINE  = 12'h000,
  parameter logic [11:0] COL_FILL     = 12'hFFF,
  parameter logic [11:0] COL_CLICK    = 12'hF80,
  parameter logic [11:0] COL_ACCENT   = 12'h0AF
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  input  logic        enable,
  input  logic        blink_en,
  vga_if.in           in,
  vga_if.out          out
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          vblnk_prev, frame_rise;
  logic [11:0]   x_l, y_l;
  logic          click_l, visible;
  logic [CW-1:0] frame_cnt;

  assign frame_rise = in.vblnk & ~vblnk_prev;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      x_l        <= '0;
      y_l        <= '0;
      click_l    <= 1'b0;
      frame_cnt  <= '0;
      visible    <= 1'b1;
    end else begin
      vblnk_prev <= in.vblnk;
      if (frame_rise) begin
        x_l     <= xpos;
        y_l     <= ypos;
        click_l <= left;
      end
      if (!blink_en) begin
        frame_cnt <= '0;
        visible   <= 1'b1;
      end else if (frame_rise) begin
        if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          visible   <= ~visible;
        end else begin
          frame_cnt <= frame_cnt + CW'(1);
        end
      end
    end
  end

  // Stage 1: sprite-relative offset; bit 12 catches pixels left of / above the sprite.
  logic [12:0]        dx, dy;
  logic               hit;
  logic [XW+YW-1:0]   rom_addr;
  vga_pix_t           s0, s1;
  logic               hit_d, en_d;
  spr_pix_t           code;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dx       = {1'b0, in.hcount} - {1'b0, x_l};
    dy       = {1'b0, in.vcount} - {1'b0, y_l};
    hit      = (dx < 13'(SPR_W)) && (dy < 13'(SPR_H)) && !dx[12] && !dy[12]
               && !(in.hblnk || in.vblnk);
    rom_addr = {dy[YW-1:0], dx[XW-1:0]};
    s0       = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync, vsync: in.vsync,
                 hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      s1    <= '0;
      hit_d <= 1'b0;
      en_d  <= 1'b0;
    end else begin
      s1    <= s0;
      hit_d <= hit;
      en_d  <= enable;
    end
  end

  // The ROM's own read register is the stage-1 address register.
  cursor_sprite_rom #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_rom (
    .clk40MHz (clk40MHz),
    .addr     (rom_addr),
    .code     (code)
  );

  // Stage 2: palette lookup and overlay.
  logic [11:0] rgb_nxt;

  always_comb begin
    rgb_nxt = s1.rgb;
    if (hit_d && en_d && visible) begin
      case (spr_code_e'(code))
        OUTLINE: rgb_nxt = COL_OUTLINE;
        FILL:    rgb_nxt = click_l ? COL_CLICK : COL_FILL;
        ACCENT:  rgb_nxt = COL_ACCENT;
        default: rgb_nxt = s1.rgb;
      endcase
    end
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= s1.hcount;
      out.vcount <= s1.vcount;
      out.hsync  <= s1.hsync;
      out.vsync  <= s1.vsync;
      out.hblnk  <= s1.hblnk;
      out.vblnk  <= s1.vblnk;
      out.rgb    <= rgb_nxt;
    end
  end
endmodule
